// File: rtl/mux_2to1_4bit.sv
// 2-to-1 word mux with a registered copy of the result.
// Also keeps a saturating count of select changes.
module mux_2to1_4bit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  output logic [WIDTH-1:0] Out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Out_r,
  output logic             s_r,
  output logic [CNT_W-1:0] sel_changes
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign Out = s ? b : a;

  always_ff @(posedge clk) begin
    if (rst) begin
      Out_r       <= '0;
      s_r         <= 1'b0;
      sel_changes <= '0;
    end else begin
      Out_r <= Out;
      s_r   <= s;
      // s_r is the select of the previous edge
      if ((s != s_r) && (sel_changes != CNT_MAX))
        sel_changes <= sel_changes + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mux_2to1_4bit.sv
// Self-checking bench for mux_2to1_4bit.
// Expected registered results are queued at drive time.
module tb_mux_2to1_4bit;

  typedef struct {
    logic [3:0] o;
    logic       s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       s;

  logic [3:0] out;
  logic [3:0] out_r;
  logic       s_r;
  logic [7:0] cnt;
  logic [3:0] sat_out;
  logic [3:0] sat_out_r;
  logic       sat_s_r;
  logic [1:0] sat_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q[$];
  logic m_sr;
  int   m_cnt;
  int   m_sat;

  always #5 clk = ~clk;

  mux_2to1_4bit dut (
    .Out(out), .a(a), .b(b), .s(s),
    .clk(clk), .rst(rst),
    .Out_r(out_r), .s_r(s_r), .sel_changes(cnt)
  );

  mux_2to1_4bit #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .Out(sat_out), .a(a), .b(b), .s(s),
    .clk(clk), .rst(rst),
    .Out_r(sat_out_r), .s_r(sat_s_r), .sel_changes(sat_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] na, input logic [3:0] nb,
                       input logic ns);
    exp_t e;
    a = na;
    b = nb;
    s = ns;
    e.o = ns ? nb : na;
    e.s = ns;
    q.push_back(e);
    if (ns != m_sr) begin
      if (m_cnt < 255) m_cnt++;
      if (m_sat < 3) m_sat++;
    end
    m_sr = ns;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_sr  = 1'b0;
    m_cnt = 0;
    m_sat = 0;
    q.delete();
  endtask

  task automatic test_comb;
    rst = 1'b0;
    a = 4'b0000; b = 4'b1111; s = 1'b0;
    #1;
    n_chk++;
    if (out !== 4'b0000) begin
      n_fail++;
      $display("FAIL comb_s0 got=%b exp=%b", out, 4'b0000);
    end
    s = 1'b1;
    #1;
    n_chk++;
    if (out !== 4'b1111) begin
      n_fail++;
      $display("FAIL comb_s1 got=%b exp=%b", out, 4'b1111);
    end
    a = 4'b1010; b = 4'b0101;
    #1;
    n_chk++;
    if (out !== 4'b0101) begin
      n_fail++;
      $display("FAIL comb_b got=%b exp=%b", out, 4'b0101);
    end
    s = 1'b0;
    #1;
    n_chk++;
    if (out !== 4'b1010) begin
      n_fail++;
      $display("FAIL comb_a got=%b exp=%b", out, 4'b1010);
    end
    b = 4'b1100;
    #1;
    n_chk++;
    if (out !== 4'b1010) begin
      n_fail++;
      $display("FAIL comb_unsel got=%b exp=%b", out, 4'b1010);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a = 4'b0110; b = 4'b1001; s = 1'b1;
    tick();
    tick();
    n_chk++;
    if (out_r !== 4'b0000 || s_r !== 1'b0 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b/%0d exp=0000/0/0",
               out_r, s_r, cnt);
    end
    n_chk++;
    if (sat_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_sat got=%0d exp=0", sat_cnt);
    end
    n_chk++;
    if (out !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_comb got=%b exp=%b", out, 4'b1001);
    end
    rst = 1'b0;
    m_sr  = 1'b0;
    m_cnt = 0;
    m_sat = 0;
    q.delete();
  endtask

  task automatic test_pipe;
    exp_t e;
    drive(4'b0011, 4'b0000, 1'b0);
    tick();
    e = q.pop_front();
    n_chk++;
    if (out_r !== e.o || out_r !== 4'b0011) begin
      n_fail++;
      $display("FAIL pipe_a got=%b exp=%b", out_r, e.o);
    end
    drive(4'b0011, 4'b1001, 1'b1);
    tick();
    e = q.pop_front();
    n_chk++;
    if (out_r !== e.o || s_r !== e.s || cnt !== 8'(m_cnt)) begin
      n_fail++;
      $display("FAIL pipe_b got=%b/%b/%0d exp=%b/%b/%0d",
               out_r, s_r, cnt, e.o, e.s, m_cnt);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom));
      tick();
      e = q.pop_front();
      n_chk++;
      if (out_r !== e.o || s_r !== e.s || cnt !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL b2b_%0d got=%b/%b/%0d exp=%b/%b/%0d",
                 i, out_r, s_r, cnt, e.o, e.s, m_cnt);
      end
    end
  endtask

  task automatic test_counter;
    exp_t e;
    logic ns;
    do_reset();
    ns = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ns = ~ns;
      drive(4'(i), 4'(15 - i), ns);
      tick();
      e = q.pop_front();
      n_chk++;
      if (out_r !== e.o || cnt !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL cnt_toggle_%0d got=%b/%0d exp=%b/%0d",
                 i, out_r, cnt, e.o, m_cnt);
      end
    end
    n_chk++;
    if (cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL cnt_five got=%0d exp=5", cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0111, 4'b1000, ns);
      tick();
      void'(q.pop_front());
    end
    n_chk++;
    if (cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL cnt_hold got=%0d exp=5", cnt);
    end
  endtask

  task automatic test_saturate;
    logic ns;
    do_reset();
    ns = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ns = ~ns;
      drive(4'b0001, 4'b0010, ns);
      tick();
      void'(q.pop_front());
      n_chk++;
      if (sat_cnt !== 2'(m_sat)) begin
        n_fail++;
        $display("FAIL sat_%0d got=%0d exp=%0d", i, sat_cnt, m_sat);
      end
    end
    n_chk++;
    if (sat_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_final got=%0d exp=3", sat_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic ns;
    do_reset();
    ns = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ns = ~ns;
      drive(4'b1111, 4'b1111, ns);
      tick();
      void'(q.pop_front());
    end
    n_chk++;
    if (cnt !== 8'd4 || out_r !== 4'b1111) begin
      n_fail++;
      $display("FAIL mid_pre got=%0d/%b exp=4/1111", cnt, out_r);
    end
    rst = 1'b1;
    a = 4'b0101; b = 4'b1110; s = 1'b0;
    #1;
    n_chk++;
    if (out !== 4'b0101) begin
      n_fail++;
      $display("FAIL mid_comb got=%b exp=%b", out, 4'b0101);
    end
    tick();
    n_chk++;
    if (cnt !== 8'd0 || out_r !== 4'b0000 || s_r !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear got=%0d/%b/%b exp=0/0000/0",
               cnt, out_r, s_r);
    end
    s = 1'b1;
    #1;
    n_chk++;
    if (out !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_track got=%b exp=%b", out, 4'b1110);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    a = '0;
    b = '0;
    s = 1'b0;
    m_sr = 1'b0;
    m_cnt = 0;
    m_sat = 0;
    test_comb();
    test_reset();
    test_pipe();
    test_back_to_back();
    test_counter();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_2to1_4bit.md
Name: mux_2to1_4bit

Overview:
- 2-to-1 word multiplexer, 4 bits wide by default, for datapath operand selection.
- Combinational output `Out` selects `a` when `s`=0 and `b` when `s`=1.
- Registered copy `Out_r` for timing-critical consumers.
- Select-change counter `sel_changes` for debug and coverage.

Parameters:
- WIDTH, 4, data width of `a`, `b`, `Out` and `Out_r`.
- CNT_W, 8, width of the `sel_changes` counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- Out  output  WIDTH  combinational mux result.
- a  input  WIDTH  data input selected when `s`=0.
- b  input  WIDTH  data input selected when `s`=1.
- s  input  1  select.
- Out_r  output  WIDTH  registered mux result.
- s_r  output  1  registered select, i.e. the select in effect for `Out_r`.
- sel_changes  output  CNT_W  count of clock edges at which `s` differed from `s_r`.
- Port declaration order is fixed: Out, a, b, s, clk, rst, Out_r, s_r, sel_changes. Positional instantiation of the first four ports is supported.

Behaviour:
- One clock (`clk`); reset `rst` is synchronous and active-high.
- Combinational path:
  - `Out` = `s` ? `b` : `a`, bit-for-bit, zero latency.
  - Independent of `clk` and `rst`; valid even with no clock running and during reset.
  - `Out` follows changes on the selected input immediately.
  - Changes on the unselected input have no effect on `Out`.
  - `s` = X/Z: `Out` is don't-care (no X-propagation requirement beyond simulator semantics).
- Registered path, on `posedge clk`:
  - If `rst`=1: `Out_r` <= 0, `s_r` <= 0, `sel_changes` <= 0.
  - Else: `Out_r` <= (`s` ? `b` : `a`) and `s_r` <= `s`.
  - Latency: 1 cycle from `a`/`b`/`s` to `Out_r`.
- Select-change counter:
  - Not in reset and `s` != `s_r`: `sel_changes` increments by 1.
  - Saturates at all-ones; never wraps.
- Reset mid-operation: registered outputs clear on the next edge; `Out` continues to track inputs.
- First edge after reset release: `s_r`=0. If `s`=1 at that edge, it counts as one change.
- Simultaneous change of `s` and data: combinational and registered paths both use the new values.
- No internal state other than `Out_r`, `s_r` and `sel_changes`.

Test Plan:
- a=0000, b=1111, s=0 -> Out=0000. Set s=1 -> Out=1111 with no clock edge needed.
- s=1, a=1010, b=0101 -> Out=0101. Set s=0 -> Out=1010. Change b to 1100 -> Out stays 1010.
- Clocked path: rst=1 for 2 edges -> Out_r=0000, s_r=0, sel_changes=0. Release, apply a=0011, s=0 -> Out_r=0011 one edge later. Set s=1, b=1001 -> Out_r=1001 after the next edge.
- Counter: toggle s on each of 5 consecutive edges after reset -> sel_changes=5. Hold s constant for 3 edges -> sel_changes stays 5.
- Saturation: with CNT_W=2, toggle s 6 times -> sel_changes=3 and remains 3.
- Reset mid-run: sel_changes=4, Out_r=1111; assert rst for one edge -> both 0 after that edge, while Out still equals the selected input throughout.
